// File: rtl/decoder_sequencer_pkg.sv
// rtl/decoder_sequencer_pkg.sv - shared modes and helpers for the decoder sequencer
// Purpose: operating-mode encoding, output-update selector and the 2^N width helper.
// Ports: none (package).
package decoder_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_DIRECT = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_STROBE = 2'd3
  } mode_e;

  // What the out register does on the coming edge.
  typedef enum logic [1:0] {
    OUT_HOLD   = 2'd0,
    OUT_DECODE = 2'd1,
    OUT_CLEAR  = 2'd2
  } out_action_e;

  localparam int MAX_N = 6;

  function automatic int onehot_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/decoder_sequencer_if.sv
// rtl/decoder_sequencer_if.sv - control/result bundle of the decoder sequencer
// Purpose: groups the sequencer controls and registered results.
// Ports: en, mode[1:0], sel[N-1:0], load, limit[N-1:0] (master -> slave);
//        out[2^N-1:0], index[N-1:0], wrap (slave -> master).
interface decoder_sequencer_if #(
  parameter int N = 3
);
  import decoder_sequencer_pkg::*;

  localparam int W = onehot_width(N);

  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] sel;
  logic         load;
  logic [N-1:0] limit;
  logic [W-1:0] out;
  logic [N-1:0] index;
  logic         wrap;

  modport master (
    output en, mode, sel, load, limit,
    input  out, index, wrap
  );

  modport slave (
    input  en, mode, sel, load, limit,
    output out, index, wrap
  );

endinterface

// File: rtl/decoder_sequencer_decoder_n.sv
// rtl/decoder_sequencer_decoder_n.sv - combinational N-to-2^N one-hot decoder
// Purpose: one-hot decode of sel, built recursively from a 2-bit stage.
// Ports: sel[N-1:0] in; onehot[2^N-1:0] out (bit k set iff sel == k).
module decoder_n #(
  parameter int N = 3
) (
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   onehot
);

  generate
    if (N == 1) begin : g_stage1
      assign onehot = {sel[0], ~sel[0]};
    end else if (N == 2) begin : g_stage2
      assign onehot = {sel == 2'd3, sel == 2'd2, sel == 2'd1, sel == 2'd0};
    end else begin : g_recurse
      localparam int HALF = 1 << (N - 1);
      logic [HALF-1:0] lower;

      decoder_n #(.N(N - 1)) u_lower (
        .sel    (sel[N-2:0]),
        .onehot (lower)
      );

      // The top select bit steers the lower decode into the upper or lower half.
      assign onehot = {lower & {HALF{sel[N-1]}}, lower & {HALF{~sel[N-1]}}};
    end
  endgenerate

endmodule

// File: rtl/decoder_sequencer.sv
// rtl/decoder_sequencer.sv - registered one-hot decoder with direct, scan and strobe modes
// Purpose: mode mux, scan counter, wrap pulse and strobe self-clear around decoder_n.
// Ports: clk, reset (async, active-high); bus (slave modport): en, mode, sel, load,
//        limit in; out (registered one-hot), index (registered), wrap (registered pulse) out.
module decoder_sequencer
  import decoder_sequencer_pkg::*;
#(
  parameter int N              = 3,
  parameter int SCAN_RESET_IDX = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  decoder_sequencer_if.slave   bus
);

  localparam int           W       = onehot_width(N);
  localparam logic [N-1:0] RST_IDX = SCAN_RESET_IDX[N-1:0];

  logic [W-1:0] out_q, out_d;
  logic [N-1:0] index_q, index_d;
  logic         wrap_q, wrap_d;
  logic         strobe_pending_q, strobe_pending_d;

  out_action_e  out_action;
  mode_e        mode;
  logic [W-1:0] dec_out;

  assign mode = mode_e'(bus.mode);

  // Decoding the next index means out is simply a register of the decoder.
  decoder_n #(.N(N)) u_dec (
    .sel    (index_d),
    .onehot (dec_out)
  );

  always_comb begin
    index_d          = index_q;
    wrap_d           = 1'b0;
    strobe_pending_d = 1'b0;
    out_action       = OUT_HOLD;

    case (mode)
      MODE_OFF: begin
        out_action = OUT_CLEAR;
      end
      MODE_DIRECT: begin
        if (bus.en) begin
          index_d    = bus.sel;
          out_action = OUT_DECODE;
        end
      end
      MODE_SCAN: begin
        if (bus.en) begin
          out_action = OUT_DECODE;
          if (bus.load) begin
            index_d = bus.sel;
          end else if (index_q >= bus.limit) begin
            // >= so a limit lowered under the current index still wraps.
            index_d = '0;
            wrap_d  = 1'b1;
          end else begin
            index_d = index_q + N'(1);
          end
        end
      end
      default: begin
        if (bus.en && bus.load) begin
          index_d          = bus.sel;
          out_action       = OUT_DECODE;
          strobe_pending_d = 1'b1;
        end else begin
          out_action = OUT_CLEAR;
        end
      end
    endcase

    // A fired strobe always self-clears, even if the mode moved away with en low.
    if (strobe_pending_q && out_action == OUT_HOLD) begin
      out_action = OUT_CLEAR;
    end

    case (out_action)
      OUT_DECODE: out_d = dec_out;
      OUT_CLEAR:  out_d = '0;
      default:    out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q            <= '0;
      index_q          <= RST_IDX;
      wrap_q           <= 1'b0;
      strobe_pending_q <= 1'b0;
    end else begin
      out_q            <= out_d;
      index_q          <= index_d;
      wrap_q           <= wrap_d;
      strobe_pending_q <= strobe_pending_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.index = index_q;
  assign bus.wrap  = wrap_q;

endmodule
